// File: rtl/lstm_out_gate_seq.sv
//------------------------------------------------------------------------------
// Module   : lstm_out_gate_seq
// Purpose  : Per-timestep sequencer for the LSTM output-gate path: walks the
//            hidden elements and strobes gate, cell, tanh and h handshake.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module lstm_out_gate_seq #(
  parameter int HID_N    = 16,
  parameter int IW       = 4,
  parameter int GATE_LAT = 3,
  parameter int CELL_LAT = 2,
  parameter int TANH_LAT = 2,
  parameter int LW       = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  input  logic          h_ready,
  output logic          busy,
  output logic          gate_en,
  output logic          sig_o_valid_o,
  output logic          c_o_valid,
  output logic          tanh_o_valid_c,
  output logic          h_valid,
  output logic [IW-1:0] elem_idx,
  output logic          done
);

  localparam logic [2:0] c_st_idle = 3'd0;
  localparam logic [2:0] c_st_gate = 3'd1;
  localparam logic [2:0] c_st_cell = 3'd2;
  localparam logic [2:0] c_st_tanh = 3'd3;
  localparam logic [2:0] c_st_out  = 3'd4;
  localparam logic [2:0] c_st_fin  = 3'd5;

  localparam logic [LW-1:0] c_gate_last = LW'(GATE_LAT - 1);
  localparam logic [LW-1:0] c_cell_last = LW'(CELL_LAT - 1);
  localparam logic [LW-1:0] c_tanh_last = LW'(TANH_LAT - 1);
  localparam logic [IW-1:0] c_idx_last  = IW'(HID_N - 1);

  logic [2:0]    r_state;
  logic [LW-1:0] r_cnt;
  logic [IW-1:0] r_idx;

  logic [2:0]    w_state_nxt;
  logic [LW-1:0] w_cnt_nxt;
  logic [IW-1:0] w_idx_nxt;

  logic w_in_gate;
  logic w_in_cell;
  logic w_in_tanh;
  logic w_gate_last;
  logic w_cell_last;
  logic w_tanh_last;

  assign w_in_gate   = (r_state == c_st_gate);
  assign w_in_cell   = (r_state == c_st_cell);
  assign w_in_tanh   = (r_state == c_st_tanh);
  assign w_gate_last = w_in_gate && (r_cnt == c_gate_last);
  assign w_cell_last = w_in_cell && (r_cnt == c_cell_last);
  assign w_tanh_last = w_in_tanh && (r_cnt == c_tanh_last);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    case (r_state)
      c_st_idle: begin
        if (start && !abort) begin
          w_state_nxt = c_st_gate;
          w_cnt_nxt   = '0;
          w_idx_nxt   = '0;
        end
      end
      c_st_gate: begin
        if (w_gate_last) begin
          w_state_nxt = c_st_cell;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + LW'(1);
        end
      end
      c_st_cell: begin
        if (w_cell_last) begin
          w_state_nxt = c_st_tanh;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + LW'(1);
        end
      end
      c_st_tanh: begin
        if (w_tanh_last) begin
          w_state_nxt = c_st_out;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + LW'(1);
        end
      end
      c_st_out: begin
        // Element index only moves on a completed handshake.
        if (h_ready) begin
          w_cnt_nxt = '0;
          if (r_idx == c_idx_last) begin
            w_state_nxt = c_st_fin;
          end else begin
            w_state_nxt = c_st_gate;
            w_idx_nxt   = r_idx + IW'(1);
          end
        end
      end
      c_st_fin: begin
        w_state_nxt = c_st_idle;
        w_cnt_nxt   = '0;
        w_idx_nxt   = '0;
      end
      default: begin
        w_state_nxt = c_st_idle;
        w_cnt_nxt   = '0;
        w_idx_nxt   = '0;
      end
    endcase
    if (abort && (r_state != c_st_idle)) begin
      w_state_nxt = c_st_idle;
      w_cnt_nxt   = '0;
      w_idx_nxt   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_st_idle;
      r_cnt   <= '0;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  // Pure decodes of registered state, so reset clears them without a clock.
  assign busy           = (r_state != c_st_idle);
  assign gate_en        = w_in_gate && (r_cnt == '0);
  assign sig_o_valid_o  = w_gate_last;
  assign c_o_valid      = w_cell_last;
  assign tanh_o_valid_c = w_tanh_last;
  assign h_valid        = (r_state == c_st_out);
  assign done           = (r_state == c_st_fin);
  assign elem_idx       = r_idx;

endmodule

`default_nettype wire

// File: tb/tb_lstm_out_gate_seq.sv
//------------------------------------------------------------------------------
// Module   : tb_lstm_out_gate_seq
// Purpose  : Scoreboard bench for lstm_out_gate_seq (default and GATE_LAT=1).
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_lstm_out_gate_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic h_ready = 1'b1;
  logic start1 = 1'b0;

  logic       busy, gate_en, sig_v, c_v, tanh_v, h_valid, done;
  logic [3:0] elem_idx;
  logic       busy1, gate_en1, sig_v1, c_v1, tanh_v1, h_valid1, done1;
  logic [3:0] elem_idx1;

  lstm_out_gate_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .h_ready(h_ready),
    .busy(busy), .gate_en(gate_en), .sig_o_valid_o(sig_v), .c_o_valid(c_v),
    .tanh_o_valid_c(tanh_v), .h_valid(h_valid), .elem_idx(elem_idx), .done(done)
  );

  lstm_out_gate_seq #(.GATE_LAT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort), .h_ready(h_ready),
    .busy(busy1), .gate_en(gate_en1), .sig_o_valid_o(sig_v1), .c_o_valid(c_v1),
    .tanh_o_valid_c(tanh_v1), .h_valid(h_valid1), .elem_idx(elem_idx1), .done(done1)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  typedef struct {
    int kind;
    int idx;
    int cyc;
  } evt_t;
  evt_t exp_q[$];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push1(input int kind, input int idx, input int off, input int base, input int stop_off);
    evt_t e;
    if (off <= stop_off) begin
      e.kind = kind;
      e.idx  = idx;
      e.cyc  = base + off;
      exp_q.push_back(e);
    end
  endtask

  // Kinds: 0 gate_en, 1 sig, 2 cell, 3 tanh, 4 h handshake, 5 done.
  task automatic push_sched(input int base, input int bp_elem, input int bp_len, input int stop_off);
    int sh;
    int t0;
    for (int k = 0; k < 16; k++) begin
      sh = (bp_elem >= 0 && k > bp_elem) ? bp_len : 0;
      t0 = 1 + 8 * k + sh;
      push1(0, k, t0,     base, stop_off);
      push1(1, k, t0 + 2, base, stop_off);
      push1(2, k, t0 + 4, base, stop_off);
      push1(3, k, t0 + 6, base, stop_off);
      push1(4, k, t0 + 7 + ((k == bp_elem) ? bp_len : 0), base, stop_off);
    end
    push1(5, 15, 129 + ((bp_elem >= 0) ? bp_len : 0), base, stop_off);
  endtask

  task automatic mon_evt(input int kind);
    evt_t e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL event: unexpected kind=%0d idx=%0d at cycle %0d", kind, elem_idx, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.idx != int'(elem_idx) || e.cyc != cyc) begin
        bad++;
        $display("FAIL event: got kind=%0d idx=%0d cyc=%0d expected kind=%0d idx=%0d cyc=%0d",
                 kind, elem_idx, cyc, e.kind, e.idx, e.cyc);
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (gate_en) mon_evt(0);
      if (sig_v) mon_evt(1);
      if (c_v) mon_evt(2);
      if (tanh_v) mon_evt(3);
      if (h_valid && h_ready) mon_evt(4);
      if (done) mon_evt(5);
    end
  end

  task automatic goto(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic kick(output int base);
    @(posedge clk);
    #1;
    start = 1'b1;
    base = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  function automatic int outs();
    return int'({busy, gate_en, sig_v, c_v, tanh_v, h_valid, done, elem_idx});
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;

    // Reset with random inputs.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      start   = 1'($urandom_range(0, 1));
      abort   = 1'($urandom_range(0, 1));
      h_ready = 1'($urandom_range(0, 1));
      #3;
      chk("reset_outputs", outs(), 0);
    end
    @(posedge clk);
    #1;
    start = 1'b0; abort = 1'b0; h_ready = 1'b1; rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_reset_busy", busy, 0);

    // Nominal run with ignored start pulses while busy.
    kick(base);
    push_sched(base, -1, 0, 1000);
    chk("first_gate_en", gate_en, 1);
    goto(base + 10); start = 1'b1;
    goto(base + 11); start = 1'b0;
    goto(base + 50); start = 1'b1;
    goto(base + 51); start = 1'b0;
    goto(base + 129);
    chk("nominal_busy_at_done", busy, 1);
    goto(base + 130);
    chk("nominal_busy_after", busy, 0);
    chk("nominal_queue_empty", exp_q.size(), 0);

    // Backpressure on element 3.
    kick(base);
    push_sched(base, 3, 5, 1000);
    goto(base + 32); h_ready = 1'b0;
    goto(base + 34);
    chk("bp_h_valid", h_valid, 1);
    chk("bp_elem_idx", elem_idx, 3);
    goto(base + 36);
    chk("bp_h_valid_end", h_valid, 1);
    goto(base + 37); h_ready = 1'b1;
    goto(base + 134);
    chk("bp_done", done, 1);
    goto(base + 135);
    chk("bp_busy_after", busy, 0);
    chk("bp_queue_empty", exp_q.size(), 0);

    // Abort in the first CELL cycle of element 2.
    kick(base);
    push_sched(base, -1, 0, 20);
    goto(base + 20); abort = 1'b1;
    goto(base + 21); abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_elem_idx", elem_idx, 0);
    goto(base + 30);
    chk("abort_queue_empty", exp_q.size(), 0);
    kick(base);
    push_sched(base, -1, 0, 1000);
    goto(base + 130);
    chk("after_abort_queue_empty", exp_q.size(), 0);

    // start and abort together in IDLE.
    @(posedge clk);
    #1;
    start = 1'b1; abort = 1'b1;
    @(posedge clk);
    #1;
    chk("start_abort_idle", busy, 0);
    start = 1'b0; abort = 1'b0;
    @(posedge clk);
    #1;
    chk("start_abort_idle2", busy, 0);

    // Asynchronous reset during TANH of element 5.
    kick(base);
    push_sched(base, -1, 0, 46);
    goto(base + 46);
    chk("pre_async_busy", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", outs(), 0);
    goto(cyc + 2);
    rst_n = 1'b1;
    chk("async_queue_empty", exp_q.size(), 0);
    kick(base);
    push_sched(base, -1, 0, 1000);
    goto(base + 130);
    chk("after_async_queue_empty", exp_q.size(), 0);

    // GATE_LAT=1 instance: gate_en and sig strobe together, 6-cycle period.
    @(posedge clk);
    #1;
    start1 = 1'b1;
    base = cyc;
    goto(base + 1); start1 = 1'b0;
    chk("gl1_gate_sig", int'({gate_en1, sig_v1}), 3);
    goto(base + 2);
    chk("gl1_idle_strobes", int'({gate_en1, sig_v1, c_v1, tanh_v1}), 0);
    goto(base + 3);
    chk("gl1_cell", c_v1, 1);
    goto(base + 5);
    chk("gl1_tanh", tanh_v1, 1);
    goto(base + 6);
    chk("gl1_h_valid", h_valid1, 1);
    goto(base + 7);
    chk("gl1_next_gate", int'({gate_en1, sig_v1, elem_idx1}), 'h31);
    goto(base + 97);
    chk("gl1_done", done1, 1);
    goto(base + 98);
    chk("gl1_busy_after", busy1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
